// File: rtl/addr_cmd_latch.sv
// Captures multi-chunk addresses and single-chunk commands from a narrow
// strobed IO bus (NAND-style ALE/CLE/WE protocol).
module addr_cmd_latch #(
  parameter int IO_W      = 4,
  parameter int ADDR_W    = 12,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IO_W-1:0]   IO,
  input  logic              CE,
  input  logic              WE,
  input  logic              ALE,
  input  logic              CLE,
  input  logic              addr_ack,
  output logic [ADDR_W-1:0] address,
  output logic              address_ready,
  output logic [IO_W-1:0]   cmd,
  output logic              cmd_valid,
  output logic              addr_abort,
  output logic              overrun
);

  localparam int NCHUNK = ADDR_W / IO_W;
  localparam int CW     = (NCHUNK > 2) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    READY
  } state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   shreg_reg, shreg_next;
  logic [ADDR_W-1:0]   address_reg, address_next;
  logic                ready_reg, ready_next;
  logic [IO_W-1:0]     cmd_reg, cmd_next;
  logic                cmd_valid_reg, cmd_valid_next;
  logic                abort_reg, abort_next;
  logic                overrun_reg, overrun_next;
  logic                we_q_reg;

  logic                we_edge;
  logic                addr_wr;
  logic                cmd_wr;
  logic [ADDR_W-1:0]   shifted;

  assign we_edge = WE & ~we_q_reg;
  assign addr_wr = we_edge & ~CE & ALE & ~CLE;
  assign cmd_wr  = we_edge & ~CE & CLE & ~ALE;

  // After NCHUNK shifts the first chunk has reached its final slot.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shifted = {shreg_reg[ADDR_W-IO_W-1:0], IO};
    end else begin : g_lsb_first
      assign shifted = {IO, shreg_reg[ADDR_W-1:IO_W]};
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shreg_next     = shreg_reg;
    address_next   = address_reg;
    ready_next     = ready_reg;
    cmd_next       = cmd_reg;
    cmd_valid_next = cmd_wr;
    abort_next     = 1'b0;
    overrun_next   = overrun_reg;

    if (cmd_wr) begin
      cmd_next = IO;
    end

    case (state_reg)
      IDLE: begin
        if (addr_wr) begin
          shreg_next = shifted;
          cnt_next   = CW'(1);
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        // A command write always has ALE low, so it falls into this abort.
        if (CE || !ALE) begin
          shreg_next = '0;
          cnt_next   = '0;
          abort_next = 1'b1;
          state_next = IDLE;
        end else if (addr_wr) begin
          if (cnt_reg == LAST_CHUNK) begin
            address_next = shifted;
            ready_next   = 1'b1;
            shreg_next   = '0;
            cnt_next     = '0;
            state_next   = READY;
          end else begin
            shreg_next = shifted;
            cnt_next   = cnt_reg + CW'(1);
          end
        end
      end
      READY: begin
        if (addr_ack) begin
          ready_next   = 1'b0;
          overrun_next = 1'b0;
          state_next   = IDLE;
        end else if (addr_wr) begin
          overrun_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // we_q resets high so a WE already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shreg_reg     <= '0;
      address_reg   <= '0;
      ready_reg     <= 1'b0;
      cmd_reg       <= '0;
      cmd_valid_reg <= 1'b0;
      abort_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
      we_q_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shreg_reg     <= shreg_next;
      address_reg   <= address_next;
      ready_reg     <= ready_next;
      cmd_reg       <= cmd_next;
      cmd_valid_reg <= cmd_valid_next;
      abort_reg     <= abort_next;
      overrun_reg   <= overrun_next;
      we_q_reg      <= WE;
    end
  end

  assign address       = address_reg;
  assign address_ready = ready_reg;
  assign cmd           = cmd_reg;
  assign cmd_valid     = cmd_valid_reg;
  assign addr_abort    = abort_reg;
  assign overrun       = overrun_reg;

endmodule

// File: doc/addr_cmd_latch.md
ADDR_CMD_LATCH -- requirements
Module: addr_cmd_latch

Interface
REQ-001 SHALL have parameter IO_W, default 4: width of IO bus and of each captured chunk.
REQ-002 SHALL have parameter ADDR_W, default 12: assembled address width; must be an integer multiple of IO_W, with NCHUNK = ADDR_W/IO_W >= 2.
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 = first chunk lands in bits [IO_W-1:0]; 1 = first chunk lands in the top IO_W bits.
REQ-004 SHALL have ports: clk  in  1  clock, rising edge; one clock domain.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 IO  in  IO_W  address/command data bus.
REQ-007 CE  in  1  chip enable, active-low.
REQ-008 WE  in  1  write strobe; data captured on its 0->1 transition.
REQ-009 ALE  in  1  address latch enable, active-high.
REQ-010 CLE  in  1  command latch enable, active-high.
REQ-011 addr_ack  in  1  one-cycle consume pulse from downstream.
REQ-012 address  out  ADDR_W  assembled address, registered.
REQ-013 address_ready  out  1  address valid, held until acknowledged.
REQ-014 cmd  out  IO_W  last captured command, registered.
REQ-015 cmd_valid  out  1  one-cycle pulse per captured command.
REQ-016 addr_abort  out  1  one-cycle pulse when a partial address is discarded.
REQ-017 overrun  out  1  sticky: address write arrived while address_ready was high.

Function
REQ-018 All inputs SHALL be synchronous to clk; WE edge = WE==1 this cycle and registered we_q==0.
REQ-019 Address write SHALL be an edge with CE==0, ALE==1, CLE==0; command write an edge with CE==0, CLE==1, ALE==0; edges with ALE==CLE or CE==1 SHALL be ignored.
REQ-020 FSM SHALL have states IDLE, COLLECT, READY; chunk counter SHALL count 0..NCHUNK-1.
REQ-021 IDLE: address write stores chunk 0, counter=1, -> COLLECT (-> READY directly is not possible since NCHUNK>=2).
REQ-022 COLLECT: each address write stores the next chunk at position per MSB_FIRST; the write storing chunk NCHUNK-1 SHALL update address and set address_ready on the following clock edge (1-cycle latency), counter -> 0, state -> READY.
REQ-023 address SHALL change only on completion of a full NCHUNK sequence; partial chunks SHALL live in an internal shift register.
REQ-024 COLLECT: ALE==0, CE==1, or a command write before completion SHALL discard the partial chunks, clear the counter, pulse addr_abort for one cycle, -> IDLE; address unchanged.
REQ-025 READY: address writes SHALL be ignored for capture and SHALL set overrun; address and address_ready hold.
REQ-026 READY: addr_ack==1 SHALL clear address_ready and overrun next edge, -> IDLE; addr_ack in IDLE/COLLECT SHALL be ignored.
REQ-027 READY with addr_ack and an address write in the same cycle: ack wins, write ignored, overrun ends 0.
REQ-028 Command write in any state SHALL load cmd from IO and pulse cmd_valid the next cycle; in READY it SHALL not disturb address/address_ready.
REQ-029 WE held high SHALL produce exactly one capture; back-to-back edges every 2 cycles SHALL all be captured.

Reset
REQ-030 rst_n==0 at a clk edge SHALL set state IDLE, counter 0, shift register 0, address 0, address_ready 0, cmd 0, cmd_valid 0, addr_abort 0, overrun 0, and we_q 1 (WE high at reset release creates no edge).
REQ-031 Reset during COLLECT or READY SHALL discard all progress with no addr_abort pulse.

Verification (defaults unless stated)
REQ-032 CE=0, ALE=1, WE edges with IO=1,2,4 -> address=12'h421, address_ready=1 one cycle after third edge; no abort.
REQ-033 MSB_FIRST=1, same stimulus -> address=12'h124.
REQ-034 Two edges (IO=3,5) then ALE=0 -> addr_abort one-cycle pulse, address unchanged; then IO=A,B,C -> address=12'hCBA.
REQ-035 While address_ready=1, address write IO=F -> overrun=1, address unchanged; addr_ack pulse -> address_ready=0, overrun=0 next cycle.
REQ-036 CE=0, CLE=1, ALE=0, edge with IO=9 -> cmd=4'h9, cmd_valid high exactly one cycle; again during READY -> address_ready stays 1.
REQ-037 rst_n=0 after one chunk, WE held high through release -> all outputs 0, no capture until a fresh WE 0->1.
